dqn_weight_loader: RTL and testbench

//  Upstream stage of the DQN top. Accepts a flat 32-bit weight word stream from the host link
//  (valid/ready) and sequences it into per-layer (layer, addr, weight) writes for the ANN

---
 rtl/dqn_pkg.sv | 38 +++
 rtl/dqn_weight_loader.sv | 141 ++++++++++++++
 tb/tb_dqn_weight_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN weight loader: layer codes, FSM state
// encoding and per-layer word counts (bias words included).
package dqn_pkg;

    localparam int LAYER_H1  = 0;
    localparam int LAYER_H2  = 1;
    localparam int LAYER_OUT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Each node of a layer has one weight per input of that layer plus a bias.
    function automatic int layer_words(
        input int layer,
        input int n_in,
        input int n_h1,
        input int n_h2,
        input int n_out
    );
        if (layer == LAYER_H1) begin
            return (n_in + 1) * n_h1;
        end else if (layer == LAYER_H2) begin
            return (n_h1 + 1) * n_h2;
        end else begin
            return (n_h2 + 1) * n_out;
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dqn_weight_loader.sv
// Sequences a flat host weight stream into (layer, addr, weight) writes:
// hidden-1 block, then hidden-2, then output; addresses 0..N-1 per layer.
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_start                  begin a load (honoured in IDLE only)
//   i_data_valid, i_data     host word stream
//   o_data_ready             accepting words (LOAD state)
//   o_weight_valid/_layer/_addr/o_weight   registered write to ANN memories
//   o_load_weight_done       1-cycle pulse after the final word
//   o_busy                   high in LOAD and DONE
module dqn_weight_loader
    import dqn_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int WEIGHT_COUNTER_WIDTH          = 11,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic                            i_data_valid,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_data_ready,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    output logic                            o_load_weight_done,
    output logic                            o_busy
);

    localparam int LW  = LAYER_WIDTH;
    localparam int WCW = WEIGHT_COUNTER_WIDTH;

    localparam int L1W = layer_words(LAYER_H1,
        NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1,
        NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
    localparam int L2W = layer_words(LAYER_H2,
        NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1,
        NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
    localparam int L3W = layer_words(LAYER_OUT,
        NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1,
        NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
    localparam int MAXW = max3(L1W, L2W, L3W);

    if (MAXW > 2 ** WCW) begin : g_wcw_check
        $error("WEIGHT_COUNTER_WIDTH too small for largest layer");
    end

    state_t state_q, state_d;

    logic [LW-1:0]         layer_q;
    logic [WCW-1:0]        addr_q;
    logic                  wvalid_q;
    logic [LW-1:0]         wlayer_q;
    logic [WCW-1:0]        waddr_q;
    logic [DATA_WIDTH-1:0] weight_q;
    logic                  done_q;

    logic [WCW-1:0] last_addr;
    logic           accept;
    logic           layer_end;
    logic           last_word;

    always_comb begin
        last_addr = WCW'(L3W - 1);
        if (layer_q == LW'(LAYER_H1)) begin
            last_addr = WCW'(L1W - 1);
        end else if (layer_q == LW'(LAYER_H2)) begin
            last_addr = WCW'(L2W - 1);
        end
    end

    assign o_data_ready = (state_q == ST_LOAD);
    assign o_busy       = (state_q != ST_IDLE);
    assign accept       = i_data_valid & o_data_ready;
    assign layer_end    = (addr_q == last_addr);
    assign last_word    = accept & layer_end
                        & (layer_q == LW'(LAYER_OUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start)   state_d = ST_LOAD;
            ST_LOAD: if (last_word) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_q  <= '0;
            addr_q   <= '0;
            wvalid_q <= 1'b0;
            wlayer_q <= '0;
            waddr_q  <= '0;
            weight_q <= '0;
            done_q   <= 1'b0;
        end else begin
            wvalid_q <= accept;
            done_q   <= last_word;
            if (accept) begin
                wlayer_q <= layer_q;
                waddr_q  <= addr_q;
                weight_q <= i_data;
                if (layer_end) begin
                    addr_q  <= '0;
                    layer_q <= layer_q + LW'(1);
                end else begin
                    addr_q <= addr_q + WCW'(1);
                end
            end
            // Layer counter steps past the output layer on the final
            // accept; the DONE cycle (never accepting) returns it to 0.
            if (state_q == ST_DONE) begin
                layer_q <= '0;
                addr_q  <= '0;
            end
        end
    end

    assign o_weight_valid     = wvalid_q;
    assign o_weight_layer     = wlayer_q;
    assign o_weight_addr      = waddr_q;
    assign o_weight           = weight_q;
    assign o_load_weight_done = done_q;

endmodule

// File: tb/tb_dqn_weight_loader.sv
// Self-checking bench for dqn_weight_loader: a default-size instance and a
// small-network instance, checked against a word-index reference model.
module tb_dqn_weight_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st1, v1, r1, wv1, dn1, b1;
    logic [31:0] d1, w1;
    logic [1:0]  ly1;
    logic [10:0] ad1;

    logic        st2, v2, r2, wv2, dn2, b2;
    logic [31:0] d2, w2;
    logic [1:0]  ly2;
    logic [10:0] ad2;

    dqn_weight_loader dut1 (
        .clk(clk), .rst(rst), .i_start(st1), .i_data_valid(v1),
        .i_data(d1), .o_data_ready(r1), .o_weight_valid(wv1),
        .o_weight_layer(ly1), .o_weight_addr(ad1), .o_weight(w1),
        .o_load_weight_done(dn1), .o_busy(b1)
    );

    dqn_weight_loader #(
        .NUMBER_OF_INPUT_NODE(1),
        .NUMBER_OF_HIDDEN_NODE_LAYER_1(2),
        .NUMBER_OF_HIDDEN_NODE_LAYER_2(2),
        .NUMBER_OF_OUTPUT_NODE(1)
    ) dut2 (
        .clk(clk), .rst(rst), .i_start(st2), .i_data_valid(v2),
        .i_data(d2), .o_data_ready(r2), .o_weight_valid(wv2),
        .o_weight_layer(ly2), .o_weight_addr(ad2), .o_weight(w2),
        .o_load_weight_done(dn2), .o_busy(b2)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the load is just a running word index; layer and
    // address follow from cumulative layer sizes.
    typedef enum {M_IDLE, M_LOAD, M_DONE} mst_t;
    mst_t ms[2];
    int   mk[2];

    function automatic int lsize(int sel, int l);
        int a1[3] = '{96, 1056, 99};
        int a2[3] = '{4, 6, 3};
        return (sel == 0) ? a1[l] : a2[l];
    endfunction

    function automatic int total(int sel);
        return lsize(sel, 0) + lsize(sel, 1) + lsize(sel, 2);
    endfunction

    task automatic idx2la(int sel, int idx, output int l, output int a);
        l = 0;
        a = idx;
        while (l < 2 && a >= lsize(sel, l)) begin
            a = a - lsize(sel, l);
            l++;
        end
    endtask

    // One clock: drive at negedge, predict, sample at the next negedge.
    task automatic cyc(int sel, logic s, logic v, logic [31:0] d,
                       output logic acc);
        int   idx, el, ea;
        logic edn;
        logic rdy, wv, dn, bs;
        logic [1:0]  ly;
        logic [10:0] ad;
        logic [31:0] w;
        if (sel == 0) begin
            st1 = s; v1 = v; d1 = d; st2 = 0; v2 = 0;
        end else begin
            st2 = s; v2 = v; d2 = d; st1 = 0; v1 = 0;
        end
        acc = v && (ms[sel] == M_LOAD);
        idx = mk[sel];
        edn = 1'b0;
        case (ms[sel])
            M_IDLE: if (s) ms[sel] = M_LOAD;
            M_LOAD: if (acc) begin
                mk[sel]++;
                if (mk[sel] == total(sel)) begin
                    ms[sel] = M_DONE;
                    edn = 1'b1;
                end
            end
            default: begin
                ms[sel] = M_IDLE;
                mk[sel] = 0;
            end
        endcase
        @(negedge clk);
        rdy = sel ? r2 : r1;
        wv  = sel ? wv2 : wv1;
        dn  = sel ? dn2 : dn1;
        bs  = sel ? b2 : b1;
        ly  = sel ? ly2 : ly1;
        ad  = sel ? ad2 : ad1;
        w   = sel ? w2 : w1;
        chk("ready", rdy, ms[sel] == M_LOAD);
        chk("busy", bs, ms[sel] != M_IDLE);
        chk("wvalid", wv, acc);
        chk("done", dn, edn);
        if (acc) begin
            idx2la(sel, idx, el, ea);
            chk("layer", ly, el);
            chk("addr", ad, ea);
            chk("weight", w, d);
        end
    endtask

    task automatic load(int sel, int gapmax, int restart_at, int stop_at);
        logic acc;
        int   k = 0;
        int   guard = 0;
        int   g;
        cyc(sel, 1, 0, 0, acc);
        while (k < stop_at && guard < 20000) begin
            g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            repeat (g) cyc(sel, 0, 0, $urandom, acc);
            cyc(sel, k == restart_at, 1, k, acc);
            if (acc) k++;
            guard++;
        end
        chk("load_bound", k, stop_at);
    endtask

    typedef struct {
        logic        s, v;
        logic [31:0] d;
        logic        e_rdy, e_wv;
        logic [1:0]  e_l;
        logic [10:0] e_a;
        logic        e_dn, e_busy;
    } vec_t;

    vec_t tbl[15];
    int   lay[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2};
    int   adr[13] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 0, 1, 2};

    initial begin
        logic acc;
        int   ndone;
        rst = 1'b1;
        st1 = 0; v1 = 0; d1 = 0;
        st2 = 0; v2 = 0; d2 = 0;
        ms[0] = M_IDLE; ms[1] = M_IDLE;
        mk[0] = 0; mk[1] = 0;

        tbl[0] = '{1, 1, 32'h0, 1, 0, 2'd0, 11'd0, 0, 1};
        for (int i = 0; i < 13; i++) begin
            tbl[i+1] = '{0, 1, 32'hA500 + i, (i < 12), 1,
                         2'(lay[i]), 11'(adr[i]), (i == 12), 1};
        end
        tbl[14] = '{0, 1, 32'hFFFF, 0, 0, 2'd0, 11'd0, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst_ready", r1, 0);
        chk("rst_wvalid", wv1, 0);
        chk("rst_busy", b1, 0);
        chk("rst_done", dn1, 0);
        chk("rst_layer", ly1, 0);
        chk("rst_addr", ad1, 0);
        chk("rst_weight", w1, 0);
        rst = 1'b0;

        // Small network, table-driven: 4+6+3 words then done.
        for (int i = 0; i < 15; i++) begin
            st2 = tbl[i].s; v2 = tbl[i].v; d2 = tbl[i].d;
            @(negedge clk);
            chk("t_ready", r2, tbl[i].e_rdy);
            chk("t_wvalid", wv2, tbl[i].e_wv);
            chk("t_done", dn2, tbl[i].e_dn);
            chk("t_busy", b2, tbl[i].e_busy);
            if (tbl[i].e_wv) begin
                chk("t_layer", ly2, tbl[i].e_l);
                chk("t_addr", ad2, tbl[i].e_a);
                chk("t_weight", w2, tbl[i].d);
            end
        end
        v2 = 0;

        // Small network with random gaps against the model.
        load(1, 3, -1, total(1));
        cyc(1, 0, 0, 0, acc);
        cyc(1, 0, 0, 0, acc);

        // Full stream, valid held high.
        load(0, 0, -1, total(0));
        cyc(0, 0, 0, 0, acc);

        // Random 0-5 cycle gaps.
        load(0, 5, -1, total(0));
        cyc(0, 0, 0, 0, acc);

        // i_start re-asserted mid-load is ignored.
        load(0, 0, 500, total(0));
        cyc(0, 0, 0, 0, acc);

        // Reset mid-load after 700 accepts.
        load(0, 1, -1, 700);
        chk("pre_rst_layer", ly1, 1);
        chk("pre_rst_addr", ad1, 603);
        #1 rst = 1'b1;
        #1;
        chk("arst_ready", r1, 0);
        chk("arst_wvalid", wv1, 0);
        chk("arst_busy", b1, 0);
        chk("arst_layer", ly1, 0);
        chk("arst_addr", ad1, 0);
        chk("arst_weight", w1, 0);
        v1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ms[0] = M_IDLE;
        mk[0] = 0;
        repeat (3) cyc(0, 0, 1, 32'hDEAD, acc);
        load(0, 2, -1, total(0));
        cyc(0, 0, 0, 0, acc);

        // Idle with valid high and no start.
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(0, 0, 1, $urandom, acc);
            if (dn1) ndone++;
        end
        chk("idle_no_done", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
